// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: FSM state and per-latch control.
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

  localparam int NUM_LATCH = 4;
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;
endpackage

// File: rtl/pipeline_control_if.sv
// Hazard inputs and latch/PC control outputs of the pipeline controller.
interface pipeline_control_if #(parameter int REG_W = 5, parameter int CNT_W = 32);
  logic             ihit, dhit, mem_dREN, mem_dWEN;
  logic             ex_memread, id_uses_rt;
  logic [REG_W-1:0] ex_rd, id_rs, id_rt;
  logic             jump_id, branch_taken, wb_halt;
  logic             pc_en;
  logic             ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_memread, id_uses_rt,
           ex_rd, id_rs, id_rt, jump_id, branch_taken, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_memread, id_uses_rt,
           ex_rd, id_rs, id_rt, jump_id, branch_taken, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use detection: EX-stage load writing a register the ID stage reads.
module hazard_unit #(parameter int REG_W = 5) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);
  // r0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencing: priority mux for PC/latch control, halt/data-wait FSM,
// and a saturating stall-cycle counter.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic CLK,
  input  logic RST,
  pipeline_control_if.slave bus
);
  ctrl_state_t                   state, state_nxt;
  latch_ctrl_t [NUM_LATCH-1:0]   lc;
  logic                          pc_en, load_use, dwait;
  logic [CNT_W-1:0]              cnt;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .load_use   (load_use)
  );

  assign dwait = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= RUN;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.wb_halt) state_nxt = HALTED;
               else if (dwait)  state_nxt = DWAIT;
      DWAIT:   if (bus.wb_halt) state_nxt = HALTED;
               else if (bus.dhit) state_nxt = RUN;
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    pc_en = 1'b1;
    for (int i = 0; i < NUM_LATCH; i++) begin
      lc[i].en    = 1'b1;
      lc[i].flush = 1'b0;
    end
    if (RST || state == HALTED) begin
      pc_en = 1'b0;
      for (int i = 0; i < NUM_LATCH; i++) lc[i].en = 1'b0;
    end else if (dwait) begin
      // MEM holds; WB gets a bubble so its instruction retires once
      pc_en           = 1'b0;
      lc[IFID].en     = 1'b0;
      lc[IDEX].en     = 1'b0;
      lc[EXMEM].en    = 1'b0;
      lc[MEMWB].flush = 1'b1;
    end else if (bus.branch_taken) begin
      lc[IFID].flush  = 1'b1;
      lc[IDEX].flush  = 1'b1;
      lc[EXMEM].flush = 1'b1;
    end else if (load_use) begin
      pc_en          = 1'b0;
      lc[IFID].en    = 1'b0;
      lc[IDEX].flush = 1'b1;
    end else if (bus.jump_id) begin
      pc_en          = bus.ihit;
      lc[IFID].flush = 1'b1;
    end else if (!bus.ihit) begin
      pc_en          = 1'b0;
      lc[IFID].flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (!pc_en && state != HALTED && cnt != {CNT_W{1'b1}})
      cnt <= cnt + CNT_W'(1);

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = lc[IFID].en;
  assign bus.idex_en     = lc[IDEX].en;
  assign bus.exmem_en    = lc[EXMEM].en;
  assign bus.memwb_en    = lc[MEMWB].en;
  assign bus.ifid_flush  = lc[IFID].flush;
  assign bus.idex_flush  = lc[IDEX].flush;
  assign bus.exmem_flush = lc[EXMEM].flush;
  assign bus.memwb_flush = lc[MEMWB].flush;
  assign bus.halted      = (state == HALTED);
  assign bus.stall_cnt   = cnt;
endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench: stimulus pushes expected control per cycle, monitor compares at negedge.
module tb_pipeline_control;
  localparam int REG_W = 5;
  localparam int CNT_W = 6;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipeline_control_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_control #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    bit          pc_en;
    bit [3:0]    en;   // {memwb, exmem, idex, ifid}
    bit [3:0]    fl;
    bit          halted;
    int unsigned cnt;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          total = 0, bad = 0, cyc = 0;
  bit          m_halted = 0;
  int unsigned m_cnt = 0;
  bit          last_pc_en = 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp, input int c);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  // Behavioural model: priority rules applied to the sampled inputs
  task automatic push();
    exp_t e;
    bit lu;
    if (RST) begin m_halted = 0; m_cnt = 0; end
    lu = bus.ex_memread && bus.ex_rd != 0 &&
         (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
    e.halted = m_halted; e.cnt = m_cnt; e.cyc = cyc;
    if (RST || m_halted)                                   begin e.pc_en = 0; e.en = 4'b0000; e.fl = 4'b0000; end
    else if ((bus.mem_dREN || bus.mem_dWEN) && !bus.dhit)  begin e.pc_en = 0; e.en = 4'b1000; e.fl = 4'b1000; end
    else if (bus.branch_taken)                             begin e.pc_en = 1; e.en = 4'b1111; e.fl = 4'b0111; end
    else if (lu)                                           begin e.pc_en = 0; e.en = 4'b1110; e.fl = 4'b0010; end
    else if (bus.jump_id)                                  begin e.pc_en = bus.ihit; e.en = 4'b1111; e.fl = 4'b0001; end
    else if (!bus.ihit)                                    begin e.pc_en = 0; e.en = 4'b1111; e.fl = 4'b0001; end
    else                                                   begin e.pc_en = 1; e.en = 4'b1111; e.fl = 4'b0000; end
    last_pc_en = e.pc_en;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (RST) begin m_halted = 0; m_cnt = 0; end
    else if (!m_halted) begin
      if (!last_pc_en && m_cnt < CMAX) m_cnt++;
      if (bus.wb_halt) m_halted = 1;
    end
    #1;
  endtask

  task automatic step();
    push();
    tick();
  endtask

  task automatic clear();
    bus.ihit = 1; bus.dhit = 0; bus.mem_dREN = 0; bus.mem_dWEN = 0;
    bus.ex_memread = 0; bus.ex_rd = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rt = 0; bus.jump_id = 0; bus.branch_taken = 0; bus.wb_halt = 0;
  endtask

  task automatic rand_inputs();
    bus.ihit         = ($urandom % 8) != 0;
    bus.dhit         = $urandom % 2;
    bus.mem_dREN     = ($urandom % 5) == 0;
    bus.mem_dWEN     = ($urandom % 9) == 0;
    bus.ex_memread   = ($urandom % 3) == 0;
    bus.ex_rd        = REG_W'($urandom % 4);
    bus.id_rs        = REG_W'($urandom % 4);
    bus.id_rt        = REG_W'($urandom % 4);
    bus.id_uses_rt   = $urandom % 2;
    bus.jump_id      = ($urandom % 8) == 0;
    bus.branch_taken = ($urandom % 10) == 0;
    bus.wb_halt      = ($urandom % 250) == 0;
  endtask

  always @(negedge CLK) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("pc_en", 32'(bus.pc_en), 32'(me.pc_en), me.cyc);
      chk("en", 32'({bus.memwb_en, bus.exmem_en, bus.idex_en, bus.ifid_en}), 32'(me.en), me.cyc);
      chk("flush", 32'({bus.memwb_flush, bus.exmem_flush, bus.idex_flush, bus.ifid_flush}), 32'(me.fl), me.cyc);
      chk("halted", 32'(bus.halted), 32'(me.halted), me.cyc);
      chk("stall_cnt", 32'(bus.stall_cnt), me.cnt, me.cyc);
    end
  end

  initial begin
    RST = 1;
    clear();
    #12;
    chk("rst_halted", 32'(bus.halted), 0, cyc);
    chk("rst_cnt", 32'(bus.stall_cnt), 0, cyc);
    chk("rst_pc_en", 32'(bus.pc_en), 0, cyc);
    chk("rst_en", 32'({bus.memwb_en, bus.exmem_en, bus.idex_en, bus.ifid_en}), 0, cyc);
    chk("rst_flush", 32'({bus.memwb_flush, bus.exmem_flush, bus.idex_flush, bus.ifid_flush}), 0, cyc);
    tick();
    RST = 0;

    // idle, then load-use with and without r0
    step();
    bus.ex_memread = 1; bus.ex_rd = 8; bus.id_rs = 8; step();
    bus.ex_rd = 0; bus.id_rs = 0; step();
    clear();

    // three cycles of data wait, then release
    bus.mem_dREN = 1; bus.dhit = 0;
    repeat (3) step();
    bus.dhit = 1; step();
    clear(); step();

    // branch wins over load-use
    bus.branch_taken = 1; bus.ex_memread = 1; bus.ex_rd = 3; bus.id_rs = 3; step();
    clear();

    // icache misses, then jump
    bus.ihit = 0; step(); step();
    bus.ihit = 1; bus.jump_id = 1; step();
    clear(); step();

    // halt during data wait, then asynchronous reset mid-cycle
    bus.mem_dREN = 1; step();
    bus.wb_halt = 1; step();
    bus.wb_halt = 0; step(); step();
    #2 RST = 1;
    #1;
    chk("async_halted", 32'(bus.halted), 0, cyc);
    chk("async_cnt", 32'(bus.stall_cnt), 0, cyc);
    chk("async_pc_en", 32'(bus.pc_en), 0, cyc);
    tick();
    RST = 0;
    clear(); step();

    // long miss run drives the counter into saturation
    bus.ihit = 0;
    repeat (70) step();
    clear(); step();

    // randomized traffic with occasional reset recovery from halt
    repeat (1500) begin
      rand_inputs();
      RST = (m_halted && ($urandom % 4) == 0);
      step();
    end
    RST = 0;
    clear();
    step();

    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Each cycle it decides, per inter-stage latch, whether the latch advances, holds or loads a bubble. It also decides whether the PC updates.
- Inputs: cache hit signals, load-use hazard detection, branch/jump redirects and the WB-stage halt.
- Tracks halt and data-wait state with a small FSM and keeps a stall-cycle performance counter.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- mem_dREN  in  1  MEM-stage instruction requests a data read.
- mem_dWEN  in  1  MEM-stage instruction requests a data write.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  REG_W  EX-stage destination register.
- id_rs  in  REG_W  ID-stage source register rs.
- id_rt  in  REG_W  ID-stage source register rt.
- id_uses_rt  in  1  ID-stage instruction reads rt.
- jump_id  in  1  jump resolved in ID.
- branch_taken  in  1  taken branch resolved in MEM.
- wb_halt  in  1  halt instruction is in WB.
- pc_en  out  1  PC loads its next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advances.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads a bubble. Flush overrides en.
- halted  out  1  processor stopped (registered).
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 while not halted.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values: state=RUN, halted=0, stall_cnt=0.
- While RST=1: all _en=0 and all _flush=0.

FSM states:
- RUN → DWAIT when (mem_dREN|mem_dWEN)&!dhit.
- DWAIT → RUN on dhit.
- RUN or DWAIT → HALTED when wb_halt=1 at a clock edge.
- HALTED is sticky until RST.

Control outputs:
- Combinational from current inputs and state, evaluated in strict priority order. Only the first matching case applies. Unlisted outputs take their defaults: en=1, flush=0.
- 1. HALTED: pc_en=0, all en=0, all flush=0.
- 2. Data wait ((mem_dREN|mem_dWEN)&!dhit):
  - pc_en=0; ifid_en, idex_en, exmem_en = 0.
  - memwb_flush=1, so the WB instruction retires exactly once.
- 3. branch_taken: pc_en=1; ifid_flush, idex_flush, exmem_flush = 1.
- 4. Load-use hazard (ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))):
  - pc_en=0, ifid_en=0, idex_flush=1.
- 5. jump_id: pc_en=ihit; ifid_flush=1.
- 6. !ihit: pc_en=0; ifid_flush=1.
- 7. Otherwise: all latches advance, pc_en=1.

Additional rules:
- ex_rd=0 never creates a hazard. The zero register is not forwarded from loads.
- Simultaneous events:
  - Data wait beats branch, load-use and jump.
  - Branch beats load-use, because the load-use victim is squashed.
  - wb_halt together with a data wait: HALTED is entered at the edge; the data request is abandoned.
- dhit without a request: ignored.
- stall_cnt increments by 1 at each edge where pc_en=0, state≠HALTED and RST=0. It saturates at all-ones (no wrap).
- halted rises the cycle after wb_halt is sampled. It is 0 again immediately on RST.
- Reset mid-DWAIT: state returns to RUN. The counter clears.

Decomposition:
- Shared package (cpu_types_pkg): enum ctrl_state_t {RUN, DWAIT, HALTED} and a packed struct latch_ctrl_t {en, flush}, one per latch.
- Sub-module: hazard_unit, combinational, holding the load-use compare. It is instantiated once.
- Priority mux, FSM and counter stay in pipeline_control.

Test Plan:
- Reset then ihit=1 with no hazards → pc_en=1, all en=1, all flush=0, stall_cnt=0.
- ex_memread=1, ex_rd=8, id_rs=8 → pc_en=0, ifid_en=0, idex_flush=1. Same case with ex_rd=0 → no stall.
- mem_dREN=1 with dhit=0 for 3 cycles, then dhit=1 → state DWAIT for 3 cycles, memwb_flush=1 each cycle, stall_cnt=3, release on the dhit cycle.
- branch_taken=1 coincident with a load-use hazard → ifid_flush, idex_flush, exmem_flush = 1, pc_en=1, no load-use stall.
- ihit=0 for 2 cycles → pc_en=0, ifid_flush=1 each cycle, stall_cnt +2. Then jump_id=1 with ihit=1 → pc_en=1, ifid_flush=1.
- wb_halt=1 during DWAIT → halted=1 the next cycle, all en=0 and pc_en=0 thereafter. Assert RST asynchronously mid-cycle → halted=0 and stall_cnt=0 immediately.
